// File: rtl/irda_pkg.sv
// -----------------------------------------------------------------------------
// irda_pkg
// Shared IrDA definitions used by the link arbiter, the demodulator and the
// UART blocks: link state encoding, default bit period and timer width.
// No ports (package).
// -----------------------------------------------------------------------------
package irda_pkg;

  // Clock cycles per UART bit at 50 MHz / 9600 Bd.
  localparam int unsigned IRDA_BIT_CYCLES = 5208;

  // Width of the shared bit-period timer.
  localparam int unsigned IRDA_TIMER_W = 17;

  // Link arbiter state encoding; also driven out on link_state.
  typedef enum logic [1:0] {
    IRDA_IDLE = 2'b00,
    IRDA_RX   = 2'b01,
    IRDA_TX   = 2'b10,
    IRDA_TURN = 2'b11
  } irda_state_e;

  // Terminal count for a timer that must expire after bits*cycles clocks.
  // The timer starts at zero, so the last in-window value is bits*cycles-1.
  function automatic logic [IRDA_TIMER_W-1:0] irda_terminal(
    input int unsigned bits,
    input int unsigned cycles
  );
    return IRDA_TIMER_W'(bits * cycles - 32'd1);
  endfunction

endpackage

// File: rtl/irda_bit_timer.sv
// -----------------------------------------------------------------------------
// irda_bit_timer
// Clearable 17-bit up-counter with a terminal-count compare.
// Ports:
//   clock       in   clock, posedge
//   reset       in   synchronous active-high reset (count -> 0)
//   clear       in   synchronous clear (count -> 0), overrides counting
//   terminal    in   17-bit compare value
//   at_terminal out  high while the registered count equals terminal
// -----------------------------------------------------------------------------
module irda_bit_timer
  import irda_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [IRDA_TIMER_W-1:0] terminal,
  output logic                    at_terminal
);

  logic [IRDA_TIMER_W-1:0] count_r;

  // Counter register: reset/clear to zero, otherwise count up.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + {{(IRDA_TIMER_W-1){1'b0}}, 1'b1};
    end
  end

  assign at_terminal = (count_r == terminal);

endmodule

// File: rtl/irda_link_arbiter.sv
// -----------------------------------------------------------------------------
// irda_link_arbiter
// Half-duplex IrDA link arbiter. Grants the IR LED to the UART transmitter
// only when the optical receiver is quiet, blanks the demodulator while
// transmitting and for a turnaround window afterwards, and flags a
// simultaneous transmit request / receive start seen in IDLE.
//
// Build option: define IRDA_ARB_TX_PRIORITY_EN to let the transmitter win a
// simultaneous TX request / RX start; by default the receiver wins.
//
// Parameters:
//   BIT_CYCLES    clock cycles per UART bit
//   RX_IDLE_BITS  pulse-free bit times that end a receive session
//   TURN_BITS     bit times of receiver blanking after a transmission
// Ports:
//   clock             in   clock, posedge
//   reset             in   synchronous active-high reset
//   tx_req            in   transmitter has a frame pending (level)
//   tx_done           in   transmitter finished its frame (1-cycle pulse)
//   rx_ir_data        in   raw IR receiver line, idle high, low = pulse
//   tx_grant          out  transmitter may drive the IR LED
//   im_not_receiving  out  forces the demodulator UART output idle
//   link_state        out  registered state (00 IDLE,01 RX,10 TX,11 TURN)
//   collision         out  1-cycle pulse on TX request + RX start in IDLE
// All outputs are registered and change one edge after the causing input.
// -----------------------------------------------------------------------------
module irda_link_arbiter
  import irda_pkg::*;
#(
  parameter int unsigned BIT_CYCLES   = IRDA_BIT_CYCLES,
  parameter int unsigned RX_IDLE_BITS = 11,
  parameter int unsigned TURN_BITS    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_req,
  input  logic       tx_done,
  input  logic       rx_ir_data,
  output logic       tx_grant,
  output logic       im_not_receiving,
  output logic [1:0] link_state,
  output logic       collision
);

  localparam logic [IRDA_TIMER_W-1:0] RX_TC   = irda_terminal(RX_IDLE_BITS, BIT_CYCLES);
  localparam logic [IRDA_TIMER_W-1:0] TURN_TC = irda_terminal(TURN_BITS, BIT_CYCLES);

  irda_state_e             state_r;
  irda_state_e             next_state_s;
  logic                    tx_grant_r;
  logic                    im_not_receiving_r;
  logic                    collision_r;
  logic                    collide_s;
  logic                    timer_clear_s;
  logic [IRDA_TIMER_W-1:0] timer_tc_s;
  logic                    timer_hit_s;

  irda_bit_timer u_timer (
    .clock       (clock),
    .reset       (reset),
    .clear       (timer_clear_s),
    .terminal    (timer_tc_s),
    .at_terminal (timer_hit_s)
  );

  // Timer control: counts only in RX (restarted by each low sample) and in
  // TURN; held at zero elsewhere so TURN always starts from zero.
  always_comb begin
    timer_clear_s = 1'b1;
    timer_tc_s    = TURN_TC;
    case (state_r)
      IRDA_RX: begin
        timer_clear_s = ~rx_ir_data;
        timer_tc_s    = RX_TC;
      end
      IRDA_TURN: begin
        timer_clear_s = 1'b0;
        timer_tc_s    = TURN_TC;
      end
      default: begin
        timer_clear_s = 1'b1;
        timer_tc_s    = TURN_TC;
      end
    endcase
  end

  // Next-state logic. A TX request during RX or TURN is simply not looked
  // at; since tx_req is a level it is picked up again once back in IDLE.
  always_comb begin
    next_state_s = IRDA_IDLE;
    case (state_r)
      IRDA_IDLE: begin
`ifdef IRDA_ARB_TX_PRIORITY_EN
        if (tx_req) begin
          next_state_s = IRDA_TX;
        end else if (!rx_ir_data) begin
          next_state_s = IRDA_RX;
        end else begin
          next_state_s = IRDA_IDLE;
        end
`else
        if (!rx_ir_data) begin
          next_state_s = IRDA_RX;
        end else if (tx_req) begin
          next_state_s = IRDA_TX;
        end else begin
          next_state_s = IRDA_IDLE;
        end
`endif
      end
      IRDA_RX: begin
        if (rx_ir_data && timer_hit_s) begin
          next_state_s = IRDA_IDLE;
        end else begin
          next_state_s = IRDA_RX;
        end
      end
      IRDA_TX: begin
        // rx_ir_data is ignored here: the receiver sees our own LED.
        if (tx_done || !tx_req) begin
          next_state_s = IRDA_TURN;
        end else begin
          next_state_s = IRDA_TX;
        end
      end
      IRDA_TURN: begin
        if (timer_hit_s) begin
          next_state_s = IRDA_IDLE;
        end else begin
          next_state_s = IRDA_TURN;
        end
      end
      default: begin
        next_state_s = IRDA_IDLE;
      end
    endcase
  end

  assign collide_s = (state_r == IRDA_IDLE) && !rx_ir_data && tx_req;

  // State and output registers. Outputs are decoded from the next state so
  // they always match the registered state (Moore) without an extra cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r            <= IRDA_IDLE;
      tx_grant_r         <= 1'b0;
      im_not_receiving_r <= 1'b0;
      collision_r        <= 1'b0;
    end else begin
      state_r            <= next_state_s;
      tx_grant_r         <= (next_state_s == IRDA_TX);
      im_not_receiving_r <= (next_state_s == IRDA_TX) || (next_state_s == IRDA_TURN);
      collision_r        <= collide_s;
    end
  end

  assign tx_grant         = tx_grant_r;
  assign im_not_receiving = im_not_receiving_r;
  assign link_state       = state_r;
  assign collision        = collision_r;

endmodule

// File: doc/irda_link_arbiter.md
IRDA_LINK_ARBITER -- requirements
Module: irda_link_arbiter

Interface
REQ-001 Parameter BIT_CYCLES, default 5208, clock cycles per UART bit (50 MHz / 9600 Bd).
REQ-002 Parameter RX_IDLE_BITS, default 11, pulse-free bit times that end a receive session.
REQ-003 Parameter TURN_BITS, default 2, bit times of receiver blanking after a transmission.
REQ-004 clock  in  1  single clock; all logic on posedge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tx_req  in  1  level; UART transmitter holds a frame pending until granted and finished.
REQ-007 tx_done  in  1  one-cycle pulse; transmitter has finished its frame.
REQ-008 rx_ir_data  in  1  raw IR receiver line; idle high; low means an optical pulse.
REQ-009 tx_grant  out  1  transmitter may drive the IR LED.
REQ-010 im_not_receiving  out  1  blanks the demodulator; high forces its UART output to idle.
REQ-011 link_state  out  2  current arbiter state encoding.
REQ-012 collision  out  1  one-cycle pulse on a simultaneous TX request and RX start in IDLE.

Function
REQ-013 The FSM SHALL have states IDLE=00, RX=01, TX=10 and TURN=11; link_state equals the registered state.
REQ-014 Outputs SHALL be Moore-decoded from the registered state; an input change SHALL take effect on outputs exactly one clock edge later.
REQ-015 IDLE: tx_grant=0, im_not_receiving=0; rx_ir_data==0 -> RX; else tx_req==1 -> TX.
REQ-016 RX: tx_grant=0, im_not_receiving=0; the 17-bit timer clears on every cycle with rx_ir_data==0 and otherwise increments.
REQ-017 RX: timer == RX_IDLE_BITS*BIT_CYCLES-1 with rx_ir_data==1 -> IDLE, so the link returns to IDLE exactly RX_IDLE_BITS*BIT_CYCLES cycles after the last low sample.
REQ-018 tx_req asserted during RX or TURN SHALL be held off (not dropped); the request is serviced on a later IDLE evaluation.
REQ-019 TX: tx_grant=1, im_not_receiving=1; rx_ir_data is ignored (LED echo).
REQ-020 TX: tx_done==1, or tx_req==0 (abort), -> TURN; the timer clears on entry.
REQ-021 TURN: tx_grant=0, im_not_receiving=1; timer == TURN_BITS*BIT_CYCLES-1 -> IDLE; all inputs ignored.
REQ-022 collision SHALL pulse high for one cycle, registered, when in IDLE with rx_ir_data==0 and tx_req==1 on the same cycle; the winning state is set by REQ-026.
REQ-023 tx_done outside TX SHALL be ignored.

Reset
REQ-024 On reset the FSM SHALL go to IDLE and the timer to 0, with tx_grant=0, im_not_receiving=0, link_state=00 and collision=0 after the edge.
REQ-025 Reset asserted mid-TX SHALL drop tx_grant at that edge with no TURN blanking.

Configuration
REQ-026 Macro IRDA_ARB_TX_PRIORITY_EN: when defined, the REQ-022 simultaneous case goes to TX; when undefined, it goes to RX (the REQ-015 default); collision pulses in both builds.

Structure
REQ-027 Package irda_pkg SHALL hold the state typedef/encoding and the BIT_CYCLES default constant, shared with the demodulator and UART blocks.
REQ-028 Sub-module irda_bit_timer SHALL implement the clearable 17-bit up-counter with a terminal-count compare input; the arbiter instantiates one.

Verification
REQ-029 Reset, then tx_req=1 with rx_ir_data=1 -> link_state=10 and tx_grant=1 one cycle later; tx_done pulse -> tx_grant=0, im_not_receiving=1 for 10416 cycles, then IDLE.
REQ-030 In IDLE, one rx_ir_data low pulse -> RX; IDLE exactly 57288 cycles after the last low sample; a second pulse at cycle 30000 restarts the count.
REQ-031 tx_req raised during RX -> tx_grant stays 0 until RX times out; TX is entered on the next edge after reaching IDLE.
REQ-032 rx_ir_data=0 and tx_req=1 on the same IDLE cycle -> collision one-cycle pulse; link_state=01 without the macro, 10 with it.
REQ-033 Reset asserted in TX and in TURN -> all outputs 0 and link_state=00 after one edge; tx_done during TURN has no effect.
